// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake and
// presents each instruction until released. Optional counters: FETCH_PERF_EN.
module fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              stall,
  input  logic              jmp_flag,
  input  logic [31:0]       jmp_address,
  input  logic              branch_flag,
  input  logic              branch_taken
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_instr_count,
  output logic [31:0]       perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_off;
  logic              ack_take;
  logic              issue_exit;

  assign ack_take   = (state == S_FETCH) && imem_ack;
  assign issue_exit = (state == S_ISSUE) && !stall;

  // The request and "instruction in flight" flag follow the state directly,
  // so a reset drops them in the same instant the state register clears.
  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_ISSUE);
  assign imem_addr   = pc;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (imem_ack) state_nxt = S_ISSUE;
      S_ISSUE: if (!stall)   state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Branch offset is relative to the instruction after the held one.
  always_comb begin
    seq_pc = pc_out + ADDR_W'(1);
    br_off = ADDR_W'($signed(instr[15:0]));
    if (jmp_flag)
      next_pc = jmp_address[ADDR_W-1:0];
    else if (branch_flag && branch_taken)
      next_pc = seq_pc + br_off;
    else
      next_pc = seq_pc;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      pc_out <= RESET_PC;
      instr  <= '0;
    end else begin
      if (ack_take) begin
        instr  <= imem_rdata;
        pc_out <= pc;
      end
      if (issue_exit) begin
        pc <= next_pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_count  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (issue_exit) begin
        perf_instr_count <= perf_instr_count + 32'd1;
      end
      if ((state == S_ISSUE) && stall) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; checks use immediate assertions.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic        stall;
  logic        jmp_flag;
  logic [31:0] jmp_address;
  logic        branch_flag;
  logic        branch_taken;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_instr_count;
  logic [31:0] perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc_out       (pc_out),
    .stall        (stall),
    .jmp_flag     (jmp_flag),
    .jmp_address  (jmp_address),
    .branch_flag  (branch_flag),
    .branch_taken (branch_taken)
`ifdef FETCH_PERF_EN
    ,
    .perf_instr_count  (perf_instr_count),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in S_FETCH: check the request, return data in the same cycle and
  // check the instruction is presented on the following cycle.
  task automatic fetch_word(input logic [31:0] addr, input logic [31:0] data);
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("issue_valid", {31'b0, instr_valid}, 32'd1);
    check("issue_req", {31'b0, imem_req}, 32'd0);
    check("issue_pc_out", pc_out, addr);
    check("issue_instr", instr, data);
  endtask

  // Called in S_ISSUE: leave via a jump to target.
  task automatic jump_to(input logic [31:0] target);
    jmp_flag    = 1'b1;
    jmp_address = target;
    tick();
    jmp_flag    = 1'b0;
    jmp_address = 32'h0;
    check("jump_addr", imem_addr, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    jmp_flag = 1'b0; jmp_address = 32'h0; branch_flag = 1'b0; branch_taken = 1'b0;
    #12;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instr", instr, 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_perf_instr", perf_instr_count, 32'h0);
    check("rst_perf_stall", perf_stall_cycles, 32'h0);
`endif
    rst_n = 1'b1;
    tick();  // S_IDLE -> S_FETCH

    // Sequential fetch of addresses 0 and 1; valid lasts one cycle each.
    fetch_word(32'h0, 32'h0000_0000);
    tick();
    check("seq_valid_drop", {31'b0, instr_valid}, 32'd0);
    fetch_word(32'h1, 32'h0000_0001);

    // Jump to 5, then jump to 0x40 with a taken branch also asserted.
    jump_to(32'h5);
    fetch_word(32'h5, 32'h0000_1234);
    jmp_flag = 1'b1; jmp_address = 32'h40; branch_flag = 1'b1; branch_taken = 1'b1;
    tick();
    jmp_flag = 1'b0; jmp_address = 32'h0; branch_flag = 1'b0; branch_taken = 1'b0;
    check("jump_beats_branch", imem_addr, 32'h40);
    fetch_word(32'h40, 32'h0000_0000);

    // Taken branch: 0x10 + 1 - 4 = 0x0D.
    jump_to(32'h10);
    fetch_word(32'h10, 32'h0000_FFFC);
    branch_flag = 1'b1; branch_taken = 1'b1;
    tick();
    branch_flag = 1'b0; branch_taken = 1'b0;
    check("branch_taken_addr", imem_addr, 32'h0000_000D);
    fetch_word(32'h0D, 32'h0000_0000);

    // Not-taken branch: falls through to 0x11.
    jump_to(32'h10);
    fetch_word(32'h10, 32'h0000_FFFC);
    branch_flag = 1'b1; branch_taken = 1'b0;
    tick();
    branch_flag = 1'b0;
    check("branch_not_taken_addr", imem_addr, 32'h0000_0011);
    fetch_word(32'h11, 32'hABCD_0011);

    // Stall 4 cycles with a spurious ack and a jump request that must be ignored.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; jmp_flag = 1'b1; jmp_address = 32'h99;
      end
      tick();
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_instr", instr, 32'hABCD_0011);
      check("stall_pc_out", pc_out, 32'h11);
    end
    imem_ack = 1'b0; imem_rdata = 32'h0; jmp_flag = 1'b0; jmp_address = 32'h0;
    stall = 1'b0;
    tick();
    check("post_stall_req", {31'b0, imem_req}, 32'd1);
    check("post_stall_addr", imem_addr, 32'h12);
    check("post_stall_valid", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    check("perf_stall_cycles", perf_stall_cycles, 32'd4);
    check("perf_instr_count", perf_instr_count, 32'd8);
`endif

    // Memory wait: request and address hold for 3 cycles without ack.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_req", {31'b0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, 32'h12);
      check("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    fetch_word(32'h12, 32'h0000_0001);

    // PC wrap: 0xFFFFFFFF sequential goes to 0.
    jump_to(32'hFFFF_FFFF);
    fetch_word(32'hFFFF_FFFF, 32'h0000_0005);
    tick();
    check("wrap_addr", imem_addr, 32'h0);
    fetch_word(32'h0, 32'h0000_0007);
    tick();
    check("pre_reset_addr", imem_addr, 32'h1);

    // Reset mid-fetch: outputs return to reset values without a clock.
    rst_n = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    #1;
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_valid", {31'b0, instr_valid}, 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_pc_out", pc_out, 32'h0);
    check("midrst_instr", instr, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();  // late ack lands in S_IDLE and is ignored
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    check("late_ack_instr", instr, 32'h0);
    check("late_ack_req", {31'b0, imem_req}, 32'd1);
    check("late_ack_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the control decoder and drives its 32-bit instruction input.
- Holds the PC, fetches from instruction memory over a req/ack handshake, and presents each instruction until the datapath releases it.
- Computes the next PC: sequential, jump (decoder jump flag/address) or taken branch (decoder branch flag plus ALU not-equal result).

Parameters:
- ADDR_W, 32, PC and instruction-memory address width (word addressing).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_W  word address of the request; equals pc.
- imem_ack  input  1  memory has returned data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word from memory.
- instr  output  32  held instruction to the decoder.
- instr_valid  output  1  instr is valid and being executed.
- pc_out  output  ADDR_W  address of the held instruction.
- stall  input  1  datapath busy (e.g. multiplier running); hold the current instruction.
- jmp_flag  input  1  decoder jump flag for the held instruction.
- jmp_address  input  32  decoder jump target; the low ADDR_W bits are used.
- branch_flag  input  1  decoder branch (BNE) flag for the held instruction.
- branch_taken  input  1  ALU compare result; 1 means the operands are not equal.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=S_IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, pc_out=RESET_PC.
- States:
  - S_IDLE: outputs quiet. Moves to S_FETCH on the first clock after reset release.
  - S_FETCH: imem_req=1 and imem_addr=pc, both combinational from state. Remains in S_FETCH until imem_ack=1. On the ack edge: instr<=imem_rdata, pc_out<=pc, instr_valid<=1, next state S_ISSUE.
  - S_ISSUE: imem_req=0; instr and pc_out are held stable.
    - stall=1: remain in S_ISSUE. Jump/branch inputs are ignored while stall=1.
    - stall=0: on the edge, pc<=next_pc, instr_valid<=0, next state S_FETCH.
- next_pc priority, evaluated only in S_ISSUE with stall=0:
  1. jmp_flag=1: jmp_address[ADDR_W-1:0].
  2. branch_flag=1 and branch_taken=1: pc_out + 1 + sign_extend(instr[15:0]).
  3. Otherwise: pc_out + 1.
- All PC arithmetic is modulo 2^ADDR_W; 0xFFFFFFFF + 1 wraps to 0 with no flag.
- imem_ack outside S_FETCH is ignored and imem_rdata is not sampled.
- Latency: ack in cycle N gives instr_valid=1 in cycle N+1. With a zero-wait memory and no stall, throughput is 1 instruction per 2 cycles.
- instr is never updated while instr_valid=1.
- jmp_flag and branch_flag both 1: jump wins.
- Reset asserted mid-fetch or mid-issue aborts immediately to the reset values. An outstanding memory request is dropped; a late ack arrives in S_IDLE and is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_instr_count (32) and perf_stall_cycles (32), both reset to 0.
  - perf_instr_count increments on each S_ISSUE exit.
  - perf_stall_cycles increments on each clock in S_ISSUE with stall=1.
  - Both wrap at 2^32.
- When undefined: the counters are not built, the ports are absent, and behaviour is otherwise identical.

Test Plan:
- Sequential fetch:
  - Stimulus: reset release; memory acks in the same cycle with words 0x00000000 and 0x00000001 at addresses 0 and 1; stall=0.
  - Required: imem_addr shows 0 then 1; instr_valid pulses 1 cycle each; pc_out=0 then 1.
- Jump:
  - Stimulus: held instr at pc_out=5, jmp_flag=1, jmp_address=0x40.
  - Required: next imem_addr=0x40; jump beats a simultaneous branch_flag=1, branch_taken=1.
- Branch:
  - Taken: pc_out=0x10, instr[15:0]=0xFFFC, branch_flag=1, branch_taken=1 → next address 0x0D.
  - Not taken: same but branch_taken=0 → next address 0x11.
- Stall:
  - Stimulus: stall=1 for 4 cycles during S_ISSUE.
  - Required: instr, pc_out and instr_valid=1 stable; imem_req=0; next fetch on the cycle after stall drops. With FETCH_PERF_EN: perf_stall_cycles=4, perf_instr_count +1.
- Memory wait and spurious ack:
  - Ack delayed 3 cycles: imem_req stays 1 with a stable address.
  - Ack pulsed in S_ISSUE: instr unchanged.
- Wrap and reset:
  - pc_out=0xFFFFFFFF sequential → next address 0.
  - rst_n low mid-S_FETCH → imem_req=0 and instr_valid=0 immediately, pc=RESET_PC.
